// File: rtl/lsu_mem_master_if.sv
// Request/response handshake and data-memory pins of the load/store initiator.
// The master modport is the initiator side; slave is the core/memory side.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_byte, req_signed,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_access_addr, mem_write_data,
        output mem_write_en, mem_read
    );

    modport slave (
        output req_valid, req_write, req_byte, req_signed,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_access_addr, mem_write_data,
        input  mem_write_en, mem_read
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, byte stores done as
// read-modify-write, byte loads extended, bad accesses rejected.
module lsu_mem_master #(
    parameter logic [15:0] ADDR_LIMIT = 16'h0200
) (
    input  logic             clk,
    input  logic             reset,
    lsu_mem_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACPT,
        S_READ,
        S_WRITE,
        S_MERGE,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic        byte_q, byte_d;
    logic        sgn_q, sgn_d;
    logic        aerr_q, aerr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        ready;
    logic        hs;
    logic        acc_err;
    logic [7:0]  lane;
    logic [15:0] load_val;
    logic [15:0] merged;
    logic        rd_en;
    logic        wr_en;

    assign ready   = (state_q == S_IDLE) & ~reset;
    assign hs      = bus.req_valid & ready;
    assign acc_err = (~bus.req_byte & bus.req_addr[0])
                   | (bus.req_addr >= ADDR_LIMIT);

    // Little-endian lane select; the load path uses the live read word.
    assign lane     = addr_q[0] ? bus.mem_read_data[15:8]
                                : bus.mem_read_data[7:0];
    assign load_val = byte_q ? {{8{sgn_q & lane[7]}}, lane}
                             : bus.mem_read_data;
    assign merged   = addr_q[0] ? {wdata_q[7:0], buf_q[7:0]}
                                : {buf_q[15:8], wdata_q[7:0]};

    always_comb begin
        state_d             = state_q;
        wr_d                = wr_q;
        byte_d              = byte_q;
        sgn_d               = sgn_q;
        aerr_d              = aerr_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        buf_d               = buf_q;
        rdata_d             = rdata_q;
        err_d               = err_q;
        rd_en               = 1'b0;
        wr_en               = 1'b0;
        bus.mem_access_addr = 16'h0000;
        bus.mem_write_data  = 16'h0000;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    wr_d    = bus.req_write;
                    byte_d  = bus.req_byte;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    aerr_d  = acc_err;
                    state_d = S_ACPT;
                end
            end
            S_ACPT: begin
                if (aerr_q) begin
                    rdata_d = 16'h0000;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (wr_q & ~byte_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en               = 1'b1;
                bus.mem_access_addr = addr_q;
                buf_d               = bus.mem_read_data;
                if (wr_q) begin
                    state_d = S_MERGE;
                end else begin
                    rdata_d = load_val;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                wr_en               = 1'b1;
                bus.mem_access_addr = addr_q;
                bus.mem_write_data  = wdata_q;
                rdata_d             = 16'h0000;
                err_d               = 1'b0;
                state_d             = S_RESP;
            end
            S_MERGE: begin
                wr_en               = 1'b1;
                bus.mem_access_addr = addr_q;
                bus.mem_write_data  = merged;
                rdata_d             = 16'h0000;
                err_d               = 1'b0;
                state_d             = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset kills the strobes in the same cycle so nothing commits.
    assign bus.mem_read     = rd_en & ~reset;
    assign bus.mem_write_en = wr_en & ~reset;
    assign bus.req_ready    = ready;
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            aerr_q  <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            buf_q   <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            sgn_q   <= sgn_d;
            aerr_q  <= aerr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a word-organised memory model.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_lsu_mem_master;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.ADDR_LIMIT(16'h0200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:255];
    logic [15:0] last_wd = 16'h0000;
    int          wr_cnt  = 0;
    int          cyc     = 0;
    int          n_vec   = 0;
    int          n_bad   = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    bit          no_mem  = 1'b0;
    exp_t        expq[$];
    exp_t        me;

    assign bus.mem_read_data = mem[bus.mem_access_addr[8:1]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h1234;
            mem[8'h18] <= 16'h80FF;
            mem[8'h20] <= 16'h5555;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_access_addr[8:1]] <= bus.mem_write_data;
            last_wd <= bus.mem_write_data;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: handshakes, strobe invariants and response scoreboard.
    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            acc_cnt++;
            acc_cyc = cyc + 1;
        end
        if (bus.mem_read && bus.mem_write_en) begin
            n_vec++;
            n_bad++;
            $display("FAIL rd_wr_overlap: both strobes high at cyc %0d", cyc);
        end
        if (no_mem && (bus.mem_read || bus.mem_write_en)) begin
            n_vec++;
            n_bad++;
            $display("FAIL err_mem_touch: rd=%b we=%b want 0 0",
                     bus.mem_read, bus.mem_write_en);
        end
        if (bus.resp_valid) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: resp_valid=1 at cyc %0d want 0",
                         cyc);
            end else begin
                me = expq.pop_front();
                chk("resp_rdata", {16'h0, bus.resp_rdata}, {16'h0, me.rd});
                chk("resp_err", {31'h0, bus.resp_err}, {31'h0, me.err});
                chk("resp_cycle", cyc, me.cyc);
            end
        end
    end

    task automatic issue(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] erd, input logic eerr,
                         input int lat, input bit keep);
        int   a0;
        int   t;
        exp_t e;
        a0 = acc_cnt;
        t  = 0;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        while (acc_cnt == a0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc_cnt == a0) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: addr %h not accepted", a);
            bus.req_valid = 1'b0;
            return;
        end
        e.rd  = erd;
        e.err = eerr;
        e.cyc = acc_cyc + lat;
        expq.push_back(e);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (expq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL resp_timeout: %0d responses missing", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int t;
        int w0;
        int c1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0000;
        bus.req_wdata  = 16'h0000;

        // Reset: a request offered now must be dropped.
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0010;
        @(negedge clk);
        chk("ready_in_reset", {31'h0, bus.req_ready}, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 0);
        chk("rst_rdata", {16'h0, bus.resp_rdata}, 0);
        chk("rst_err", {31'h0, bus.resp_err}, 0);
        chk("rst_mem_pins", {bus.mem_access_addr, bus.mem_write_data}, 0);
        chk("rst_mem_strobes", {30'h0, bus.mem_read, bus.mem_write_en}, 0);
        @(posedge clk);
        #1;

        // Word store then load.
        issue(1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 2, 0);
        drain();
        chk("mem_0010", {16'h0, mem[8'h08]}, 16'hBEEF);
        issue(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 0);
        drain();

        // Byte read-modify-write on 0x0020.
        issue(1, 1, 0, 16'h0021, 16'h00AB, 16'h0000, 0, 3, 0);
        drain();
        chk("merge_wdata_hi", {16'h0, last_wd}, 16'hAB34);
        chk("mem_0020_a", {16'h0, mem[8'h10]}, 16'hAB34);
        issue(1, 1, 0, 16'h0020, 16'hFFCD, 16'h0000, 0, 3, 0);
        drain();
        chk("mem_0020_b", {16'h0, mem[8'h10]}, 16'hABCD);

        // Byte load extension from 16'h80FF.
        issue(0, 1, 1, 16'h0031, 16'h0000, 16'hFF80, 0, 2, 0);
        issue(0, 1, 0, 16'h0031, 16'h0000, 16'h0080, 0, 2, 0);
        issue(0, 1, 0, 16'h0030, 16'h0000, 16'h00FF, 0, 2, 0);
        issue(0, 1, 1, 16'h0030, 16'h0000, 16'hFFFF, 0, 2, 0);
        drain();
        chk("rdata_hold", {bus.resp_valid, bus.resp_rdata}, 16'hFFFF);

        // Rejected accesses never touch memory.
        no_mem = 1'b1;
        w0 = wr_cnt;
        issue(0, 0, 0, 16'h0011, 16'h0000, 16'h0000, 1, 1, 0);
        issue(1, 0, 0, 16'h0200, 16'h1111, 16'h0000, 1, 1, 0);
        issue(0, 1, 0, 16'h0200, 16'h0000, 16'h0000, 1, 1, 0);
        drain();
        no_mem = 1'b0;
        chk("err_no_write", wr_cnt, w0);
        chk("err_mem_0000", {16'h0, mem[8'h00]}, 0);

        // Top-of-range accesses are legal.
        issue(1, 1, 0, 16'h01FF, 16'h005A, 16'h0000, 0, 3, 0);
        issue(0, 0, 0, 16'h01FE, 16'h0000, 16'h5A00, 0, 2, 0);
        issue(0, 1, 0, 16'h01FF, 16'h0000, 16'h005A, 0, 2, 0);
        drain();

        // Reset during MERGE of a byte store to 0x0040.
        a0 = acc_cnt;
        t  = 0;
        bus.req_write  = 1'b1;
        bus.req_byte   = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0040;
        bus.req_wdata  = 16'h0077;
        bus.req_valid  = 1'b1;
        while (acc_cnt == a0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        bus.req_valid = 1'b0;
        chk("rst_test_accept", acc_cnt, a0 + 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_merge_we", {31'h0, bus.mem_write_en}, 0);
        chk("rst_merge_ready", {31'h0, bus.req_ready}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_merge_ready_after", {31'h0, bus.req_ready}, 1);
        chk("rst_merge_mem", {16'h0, mem[8'h20]}, 16'h5555);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_merge_mem_late", {16'h0, mem[8'h20]}, 16'h5555);

        // Back-pressure: valid held high across two loads.
        issue(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1);
        c1 = acc_cyc;
        a0 = acc_cnt;
        issue(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 1);
        bus.req_valid = 1'b0;
        chk("bp_single_accept", acc_cnt, a0 + 1);
        chk("bp_accept_gap", acc_cyc - c1, 4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
